// File: rtl/tcbm_drive_link.sv
// Drive-side TCBM link engine: synchronises host DAV, runs the 4-phase DAV/ACK
// handshake and bridges command/data/reply bytes to a valid/ready stream.
module tcbm_drive_link #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tcbm_data_i,
  output logic [7:0] tcbm_data_o,
  output logic       tcbm_data_oe,
  output logic [1:0] tcbm_st_o,
  input  logic       tcbm_dav_i,
  output logic       tcbm_ack_o,
  output logic [7:0] rx_cmd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic [1:0] tx_st,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_ACK,
    S_RX_WAIT,
    S_RX_HOLD,
    S_RX_ACK,
    S_TX_WAIT,
    S_TX_SETUP,
    S_TX_ACK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] dav_sync;
  logic                   dav_s;
  logic [15:0]            tmo_cnt;

  // DAV idles high, so the synchroniser resets to all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dav_sync <= '1;
    end else begin
      dav_sync <= {dav_sync[SYNC_STAGES-2:0], tcbm_dav_i};
    end
  end

  assign dav_s = dav_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      tcbm_ack_o   <= 1'b1;
      tcbm_data_oe <= 1'b0;
      tcbm_data_o  <= '0;
      tcbm_st_o    <= '0;
      rx_valid     <= 1'b0;
      rx_cmd       <= '0;
      rx_data      <= '0;
      tx_ready     <= 1'b0;
      timeout_o    <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      tx_ready  <= 1'b0;
      timeout_o <= 1'b0;
      if (state != S_IDLE) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end

      // Abort takes priority over any handshake step; each transition below
      // also restarts the stall counter.
      if (state != S_IDLE && tmo_cnt == TIMEOUT_CYCLES - 16'd1) begin
        state        <= S_IDLE;
        tcbm_ack_o   <= 1'b1;
        tcbm_data_oe <= 1'b0;
        rx_valid     <= 1'b0;
        timeout_o    <= 1'b1;
        tmo_cnt      <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!dav_s) begin
              rx_cmd     <= tcbm_data_i;
              tcbm_st_o  <= 2'b00;
              tcbm_ack_o <= 1'b0;
              state      <= S_CMD_ACK;
              tmo_cnt    <= '0;
            end
          end
          S_CMD_ACK: begin
            if (dav_s) begin
              tcbm_ack_o <= 1'b1;
              tmo_cnt    <= '0;
              case (rx_cmd)
                8'h81, 8'h82, 8'h83: state <= S_RX_WAIT;
                8'h84:               state <= S_TX_WAIT;
                default:             state <= S_IDLE;
              endcase
            end
          end
          S_RX_WAIT: begin
            if (!dav_s) begin
              rx_data  <= tcbm_data_i;
              rx_valid <= 1'b1;
              state    <= S_RX_HOLD;
              tmo_cnt  <= '0;
            end
          end
          S_RX_HOLD: begin
            if (rx_valid && rx_ready) begin
              rx_valid   <= 1'b0;
              tcbm_ack_o <= 1'b0;
              state      <= S_RX_ACK;
              tmo_cnt    <= '0;
            end
          end
          S_RX_ACK: begin
            if (dav_s) begin
              tcbm_ack_o <= 1'b1;
              state      <= S_IDLE;
              tmo_cnt    <= '0;
            end
          end
          S_TX_WAIT: begin
            if (!dav_s && tx_valid) begin
              tcbm_data_o  <= tx_data;
              tcbm_st_o    <= tx_st;
              tcbm_data_oe <= 1'b1;
              tx_ready     <= 1'b1;
              state        <= S_TX_SETUP;
              tmo_cnt      <= '0;
            end
          end
          S_TX_SETUP: begin
            tcbm_ack_o <= 1'b0;
            state      <= S_TX_ACK;
            tmo_cnt    <= '0;
          end
          S_TX_ACK: begin
            if (dav_s) begin
              tcbm_ack_o   <= 1'b1;
              tcbm_data_oe <= 1'b0;
              state        <= S_IDLE;
              tmo_cnt      <= '0;
            end
          end
          default: begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tcbm_drive_link.sv
// Bench for tcbm_drive_link: acts as the host on the cable side and as the
// SD-side consumer/producer, checking latencies and a transaction scoreboard.
module tb_tcbm_drive_link;

  localparam int unsigned   SYNC = 2;
  localparam int            LAT  = SYNC + 1;
  localparam logic [15:0]   TMO  = 16'd100;

  logic       clk;
  logic       reset;
  logic [7:0] tcbm_data_i;
  logic [7:0] tcbm_data_o;
  logic       tcbm_data_oe;
  logic [1:0] tcbm_st_o;
  logic       tcbm_dav_i;
  logic       tcbm_ack_o;
  logic [7:0] rx_cmd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic [1:0] tx_st;
  logic       tx_valid;
  logic       tx_ready;
  logic       timeout_o;

  tcbm_drive_link #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tcbm_data_i (tcbm_data_i),
    .tcbm_data_o (tcbm_data_o),
    .tcbm_data_oe(tcbm_data_oe),
    .tcbm_st_o   (tcbm_st_o),
    .tcbm_dav_i  (tcbm_dav_i),
    .tcbm_ack_o  (tcbm_ack_o),
    .rx_cmd      (rx_cmd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_st       (tx_st),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;

  // Observed activity, sampled mid-cycle.
  int rxv_cycles = 0;
  int txr_pulses = 0;
  int tmo_pulses = 0;
  logic [15:0] rx_seen[$];

  // Transaction-level expectations.
  int exp_rxv = 0;
  int exp_tx  = 0;
  int exp_tmo = 0;
  logic [15:0] rx_exp[$];

  always @(negedge clk) begin
    if (rx_valid) rxv_cycles <= rxv_cycles + 1;
    if (rx_valid && rx_ready) rx_seen.push_back({rx_cmd, rx_data});
    if (tx_ready) txr_pulses <= txr_pulses + 1;
    if (timeout_o) tmo_pulses <= tmo_pulses + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic v, output int n);
    n = 0;
    while (tcbm_ack_o !== v && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic send_cmd(input logic [7:0] c);
    int n;
    tcbm_data_i = c;
    tick();
    tcbm_dav_i = 1'b0;
    wait_ack(1'b0, n);
    chk("cmd_ack_fall_lat", n, LAT);
    tcbm_dav_i = 1'b1;
    wait_ack(1'b1, n);
    chk("cmd_ack_rise_lat", n, LAT);
    chk("rx_cmd_latched", rx_cmd, c);
  endtask

  task automatic host_write(input logic [7:0] c, input logic [7:0] d, input int dly, input logic early);
    int n;
    send_cmd(c);
    tcbm_data_i = d;
    rx_ready    = (dly == 0) ? early : 1'b0;
    tick();
    tcbm_dav_i = 1'b0;
    n = 0;
    while (rx_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("rx_valid_lat", n, LAT);
    chk("rx_data", rx_data, d);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("bp_ack_high", tcbm_ack_o, 1'b1);
      chk("bp_valid_high", rx_valid, 1'b1);
    end
    rx_ready = 1'b1;
    tick();
    chk("rx_ack_fall", tcbm_ack_o, 1'b0);
    chk("rx_valid_drop", rx_valid, 1'b0);
    rx_ready   = 1'b0;
    tcbm_dav_i = 1'b1;
    wait_ack(1'b1, n);
    chk("rx_ack_rise_lat", n, LAT);
    exp_rxv += dly + 1;
    rx_exp.push_back({c, d});
  endtask

  task automatic host_read(input logic [7:0] d, input logic [1:0] s, input int dly);
    int m;
    int exp_lat;
    send_cmd(8'h84);
    tx_valid   = 1'b0;
    tcbm_dav_i = 1'b0;
    for (int i = 0; i < dly; i++) tick();
    chk("tx_wait_ack", tcbm_ack_o, 1'b1);
    chk("tx_wait_oe", tcbm_data_oe, 1'b0);
    tx_data  = d;
    tx_st    = s;
    tx_valid = 1'b1;
    m = 0;
    while (tcbm_data_oe !== 1'b1 && m < 300) begin
      tick();
      m++;
    end
    exp_lat = (dly + 1 > LAT) ? dly + 1 : LAT;
    chk("tx_oe_lat", dly + m, exp_lat);
    chk("tx_setup_ack", tcbm_ack_o, 1'b1);
    chk("tx_data_o", tcbm_data_o, d);
    chk("tx_st_o", tcbm_st_o, s);
    tick();
    chk("tx_ack_fall", tcbm_ack_o, 1'b0);
    chk("tx_oe_held", tcbm_data_oe, 1'b1);
    tcbm_dav_i = 1'b1;
    wait_ack(1'b1, m);
    chk("tx_ack_rise_lat", m, LAT);
    chk("tx_oe_fall", tcbm_data_oe, 1'b0);
    chk("tx_st_hold", tcbm_st_o, s);
    tx_valid = 1'b0;
    exp_tx++;
  endtask

  task automatic expect_timeout(input string tag);
    int n;
    n = 0;
    while (timeout_o !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk(tag, n, TMO);
    chk("tmo_ack", tcbm_ack_o, 1'b1);
    chk("tmo_oe", tcbm_data_oe, 1'b0);
    chk("tmo_rx_valid", rx_valid, 1'b0);
    tick();
    chk("tmo_pulse_len", timeout_o, 1'b0);
    exp_tmo++;
  endtask

  initial begin
    int n;
    logic [7:0] c;
    logic [7:0] d;
    int r;

    reset       = 1'b1;
    tcbm_data_i = 8'h00;
    tcbm_dav_i  = 1'b1;
    rx_ready    = 1'b0;
    tx_data     = 8'h00;
    tx_st       = 2'b00;
    tx_valid    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_ack", tcbm_ack_o, 1'b1);
    chk("rst_oe", tcbm_data_oe, 1'b0);
    chk("rst_data_o", tcbm_data_o, 8'h00);
    chk("rst_st", tcbm_st_o, 2'b00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_cmd", rx_cmd, 8'h00);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);

    // Host write with consumer always ready: one rx_valid cycle.
    host_write(8'h83, 8'h5A, 0, 1'b1);
    // Same write under 20 clocks of back-pressure.
    host_write(8'h83, 8'h5A, 20, 1'b0);
    // Host read.
    host_read(8'hC3, 2'b10, 0);
    host_read(8'h3C, 2'b01, 6);

    // Bad command: acknowledged but never reaches the consumer.
    send_cmd(8'h7F);
    tick();
    tick();
    chk("bad_cmd_no_valid", rx_valid, 1'b0);

    // Timeout stalled in RX_WAIT with DAV held high.
    send_cmd(8'h83);
    expect_timeout("tmo_rx_wait");
    send_cmd(8'h7F);

    // Timeout stalled in TX_WAIT; tx_valid without DAV must not be taken.
    tx_valid = 1'b1;
    tx_data  = 8'hEE;
    send_cmd(8'h84);
    expect_timeout("tmo_tx_wait");
    tx_valid = 1'b0;

    // Randomised traffic.
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      d = 8'($urandom);
      if (r <= 5) begin
        tx_valid = 1'($urandom);
        host_write(8'h81 + 8'(r % 3), d, $urandom_range(0, 10), 1'($urandom));
        tx_valid = 1'b0;
      end else if (r <= 7) begin
        host_read(d, 2'($urandom), $urandom_range(0, 8));
      end else begin
        c = 8'($urandom);
        if (c >= 8'h81 && c <= 8'h84) c = 8'h7F;
        send_cmd(c);
      end
    end

    // Asynchronous reset in the middle of RX_HOLD.
    host_read(8'hA5, 2'b11, 1);
    send_cmd(8'h82);
    tcbm_data_i = 8'h11;
    tick();
    tcbm_dav_i = 1'b0;
    n = 0;
    while (rx_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("hold_valid_lat", n, LAT);
    tick();
    tick();
    exp_rxv += 2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ack", tcbm_ack_o, 1'b1);
    chk("mid_rst_oe", tcbm_data_oe, 1'b0);
    chk("mid_rst_valid", rx_valid, 1'b0);
    chk("mid_rst_st", tcbm_st_o, 2'b00);
    chk("mid_rst_cmd", rx_cmd, 8'h00);
    tcbm_dav_i = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    send_cmd(8'h7F);

    repeat (3) tick();
    chk("tot_rx_valid_cycles", rxv_cycles, exp_rxv);
    chk("tot_tx_ready_pulses", txr_pulses, exp_tx);
    chk("tot_timeout_pulses", tmo_pulses, exp_tmo);
    chk("rx_count", rx_seen.size(), rx_exp.size());
    for (int i = 0; i < rx_exp.size() && i < rx_seen.size(); i++) begin
      chk("rx_scoreboard", rx_seen[i], rx_exp[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/tcbm_drive_link.md
# tcbm_drive_link

Drive-side TCBM link engine. It sits directly downstream of the host's 6523 port pins, on the far end of the paddle cable. It synchronises the host's port A / DAV lines, runs the 4-phase DAV/ACK handshake, and turns host command and data bytes into a valid/ready byte stream for the SD-side controller. It also returns reply bytes plus 2-bit status on the same wires.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the tcbm_dav_i synchroniser (legal range 2..3)
- TIMEOUT_CYCLES, 16'd50000, clocks spent in any non-IDLE state before the transfer is aborted (16-bit)
- clk  in  1  free-running drive-side clock; all logic on posedge
- reset  in  1  asynchronous, active-high
- tcbm_data_i  in  8  port A pins as seen at the cable
- tcbm_data_o  out  8  port A value driven to host
- tcbm_data_oe  out  1  port A output enable (1 = drive)
- tcbm_st_o  out  2  status lines to host port B[1:0]
- tcbm_dav_i  in  1  host DAV (port C bit 6), active-low, asynchronous
- tcbm_ack_o  out  1  drive ACK (port C bit 7), active-low
- rx_cmd  out  8  command byte of current transfer
- rx_data  out  8  data byte from host
- rx_valid  out  1  rx_cmd/rx_data valid
- rx_ready  in  1  consumer accepts the byte
- tx_data  in  8  reply byte
- tx_st  in  2  reply status
- tx_valid  in  1  reply available
- tx_ready  out  1  one-cycle pulse: reply taken
- timeout_o  out  1  one-cycle pulse on abort

## Operation
- dav_s: tcbm_dav_i after SYNC_STAGES flops (reset value 1). Port A is captured raw in the cycle the FSM sees dav_s==0; the host sets up PA before DAV, so PA is stable by then.
- Reset values: state IDLE, tcbm_ack_o=1, tcbm_data_oe=0, tcbm_data_o=0, tcbm_st_o=00, rx_valid=0, rx_cmd=0, rx_data=0, tx_ready=0, timeout_o=0, timeout counter 0. Reset asserted mid-transfer forces all of these immediately.
- IDLE: ack=1, oe=0. On dav_s==0: latch cmd←tcbm_data_i, st←00, go CMD_ACK.
- CMD_ACK: ack=0. On dav_s==1: ack=1, then dispatch:
  - 0x81/0x82/0x83 → RX_WAIT
  - 0x84 → TX_WAIT
  - any other value → IDLE (ignored; rx never asserted)
- RX_WAIT: on dav_s==0: latch rx_data, set rx_valid=1, go RX_HOLD.
- RX_HOLD: rx_valid=1, ack stays 1 (back-pressure on host). On rx_valid&&rx_ready: rx_valid=0, ack=0, go RX_ACK.
- RX_ACK: on dav_s==1: ack=1 → IDLE.
- TX_WAIT: when dav_s==0 && tx_valid: data_o←tx_data, st←tx_st, oe=1, tx_ready pulse, go TX_SETUP. Ack stays 1 until both conditions hold.
- TX_SETUP: exactly one cycle of data setup; ack=0 at exit; go TX_ACK.
- TX_ACK: on dav_s==1: ack=1, oe=0 in the same edge → IDLE. tcbm_st_o holds until the next command byte.
- rx_cmd holds the latched command from CMD_ACK until the next command latch.
- Timeout:
  - Counter clears on every state change and counts in every non-IDLE state.
  - At count==TIMEOUT_CYCLES-1: state→IDLE, ack=1, oe=0, rx_valid=0, timeout_o pulses for one cycle.
  - tx_ready is not issued in the abort cycle.
  - Local stalls (RX_HOLD, TX_WAIT) are subject to timeout.
- Simultaneous events: a timeout wins over any handshake transition in the same cycle. rx_ready with rx_valid=0 is ignored. tx_valid outside TX_WAIT is ignored.

## Timing
- DAV pin fall → tcbm_ack_o fall: SYNC_STAGES+1 clocks (command byte, IDLE).
- DAV pin rise → ack rise: SYNC_STAGES+1 clocks.
- RX: rx_valid rises SYNC_STAGES+1 clocks after the DAV pin fall. ack falls one clock after the rx_valid&&rx_ready edge.
- TX: oe/data valid one clock before ack falls. oe falls on the same edge as ack rises.
- No combinational paths from inputs to outputs.

## Test plan
- Reset: pulse reset mid-RX_HOLD → ack=1, oe=0, rx_valid=0, st=00 immediately; dav high for 5 clocks → FSM in IDLE.
- Host write: PA=0x83 with DAV low/high handshake, then PA=0x5A with rx_ready=1 → rx_cmd=0x83, rx_data=0x5A, one rx_valid cycle; ack falls SYNC_STAGES+1 clocks after each DAV fall.
- Back-pressure: same write with rx_ready=0 for 20 clocks → ack stays 1, rx_valid stays 1; ack falls one clock after rx_ready=1.
- Host read: cmd 0x84, tx_data=0xC3, tx_st=10, tx_valid=1, DAV low → oe=1, data_o=0xC3, st=10 one clock before ack=0; single tx_ready pulse; DAV high → oe=0, ack=1.
- Bad command / timeout: cmd 0x7F → returns to IDLE, no rx_valid. With TIMEOUT_CYCLES=100, cmd 0x83 then DAV held high → timeout_o pulse at the 100th cycle in RX_WAIT, FSM in IDLE.
